// File: rtl/layer_scheduler.sv
// layer_scheduler: event FIFO plus dispatch FSM feeding the conv and pool units.
// Optional stats counters are built when LAYER_SCHEDULER_STATS_EN is defined.
module layer_scheduler #(
    parameter int COORD_BITS  = 8,
    parameter int IN_CHANNELS = 2,
    parameter int FIFO_DEPTH  = 8,
    localparam int EVW = 1 + 2 * COORD_BITS + IN_CHANNELS
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [EVW-1:0] in_event,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [EVW-1:0] conv_event,
    output logic           conv_event_valid,
    input  logic           conv_event_ack,
    input  logic           conv_busy,
    input  logic           arb_active,
    output logic           arb_conv_or_pool,
    output logic           arb_enable,
    output logic           pool_start,
    input  logic           pool_done,
    output logic [15:0]    event_count,
    output logic [15:0]    timestep_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        DISPATCH,
        CONV_WAIT,
        POOL_START,
        POOL_WAIT
    } state_t;

    state_t state, state_nx;

    logic [EVW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [PW:0]    count;
    logic           up;
    logic           empty, full;
    logic           wr_en, rd_en;
    logic [EVW-1:0] head;

    assign head     = mem[rd_ptr];
    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign in_ready = up && !full;
    assign wr_en    = in_valid && in_ready;
    assign arb_enable = up;

    // Marks the first clock after reset release; gates in_ready and arb_enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) up <= 1'b0;
        else        up <= 1'b1;
    end

    // Event storage; pointers wrap naturally because depth is a power of two.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= in_event;
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !rd_en)      count <= count + 1'b1;
            else if (!wr_en && rd_en) count <= count - 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state and Moore/Mealy outputs; timestep events are popped, never sent to conv.
    always_comb begin
        state_nx         = state;
        rd_en            = 1'b0;
        conv_event_valid = 1'b0;
        pool_start       = 1'b0;
        arb_conv_or_pool = 1'b1;
        unique case (state)
            IDLE: begin
                if (!empty) state_nx = head[EVW-1] ? POOL_START : DISPATCH;
            end
            DISPATCH: begin
                conv_event_valid = 1'b1;
                if (conv_event_ack) begin
                    rd_en    = 1'b1;
                    state_nx = CONV_WAIT;
                end
            end
            CONV_WAIT: begin
                if (!conv_busy && !arb_active) state_nx = IDLE;
            end
            POOL_START: begin
                rd_en            = 1'b1;
                pool_start       = 1'b1;
                arb_conv_or_pool = 1'b0;
                state_nx         = POOL_WAIT;
            end
            POOL_WAIT: begin
                arb_conv_or_pool = 1'b0;
                if (pool_done) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign conv_event = conv_event_valid ? head : '0;

`ifdef LAYER_SCHEDULER_STATS_EN
    logic [15:0] ev_cnt, ts_cnt;

    // Saturating counters of accepted dispatches and completed pooling passes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_cnt <= '0;
            ts_cnt <= '0;
        end else begin
            if (state == DISPATCH && conv_event_ack && ev_cnt != 16'hFFFF)
                ev_cnt <= ev_cnt + 1'b1;
            if (state == POOL_WAIT && pool_done && ts_cnt != 16'hFFFF)
                ts_cnt <= ts_cnt + 1'b1;
        end
    end

    assign event_count    = ev_cnt;
    assign timestep_count = ts_cnt;
`else
    assign event_count    = '0;
    assign timestep_count = '0;
`endif

endmodule

// File: tb/tb_layer_scheduler.sv
// tb_layer_scheduler: scenario tasks with a queue scoreboard of dispatched events.
// Expected counter values follow LAYER_SCHEDULER_STATS_EN.
module tb_layer_scheduler;

    localparam int CB  = 8;
    localparam int IC  = 2;
    localparam int EVW = 1 + 2 * CB + IC;
`ifdef LAYER_SCHEDULER_STATS_EN
    localparam int ST = 1;
`else
    localparam int ST = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [EVW-1:0] in_event, conv_event;
    logic in_valid, in_ready, conv_event_valid, conv_event_ack;
    logic conv_busy, arb_active, arb_conv_or_pool, arb_enable;
    logic pool_start, pool_done;
    logic [15:0] event_count, timestep_count;

    int total = 0;
    int bad = 0;
    logic [EVW-1:0] sb[$];
    logic [EVW-1:0] exp_ev;

    always #5 clk = ~clk;

    layer_scheduler #(.COORD_BITS(CB), .IN_CHANNELS(IC), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_event(in_event), .in_valid(in_valid), .in_ready(in_ready),
        .conv_event(conv_event), .conv_event_valid(conv_event_valid),
        .conv_event_ack(conv_event_ack), .conv_busy(conv_busy),
        .arb_active(arb_active), .arb_conv_or_pool(arb_conv_or_pool),
        .arb_enable(arb_enable), .pool_start(pool_start), .pool_done(pool_done),
        .event_count(event_count), .timestep_count(timestep_count)
    );

    function automatic logic [EVW-1:0] mk(input logic ts, input logic [7:0] x,
                                          input logic [7:0] y, input logic [1:0] sp);
        return {ts, x, y, sp};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_event = '0;
        conv_event_ack = 1'b0; conv_busy = 1'b0; arb_active = 1'b0; pool_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        sb.delete();
    endtask

    task automatic push(input logic [EVW-1:0] ev, output bit ok);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        ok = in_ready;
        in_event = ev; in_valid = 1'b1;
        if (!ev[EVW-1]) sb.push_back(ev);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        int n = 0;
        ok = 1'b0;
        while (n < 200 && !ok) begin
            @(negedge clk);
            ok = conv_event_valid;
            n++;
        end
    endtask

    task automatic pulse_ack();
        @(posedge clk); #1; conv_event_ack = 1'b1;
        @(posedge clk); #1; conv_event_ack = 1'b0;
    endtask

    task automatic pulse_done();
        @(posedge clk); #1; pool_done = 1'b1;
        @(posedge clk); #1; pool_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_event = '0;
        conv_event_ack = 1'b0; conv_busy = 1'b0; arb_active = 1'b0; pool_done = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        total++; if (conv_event_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", conv_event_valid); end
        total++; if (conv_event !== '0) begin bad++; $display("FAIL rst_event: got %h want 0", conv_event); end
        total++; if (pool_start !== 1'b0) begin bad++; $display("FAIL rst_pool_start: got %b want 0", pool_start); end
        total++; if (arb_enable !== 1'b0) begin bad++; $display("FAIL rst_arb_en: got %b want 0", arb_enable); end
        total++; if (arb_conv_or_pool !== 1'b1) begin bad++; $display("FAIL rst_arb_mode: got %b want 1", arb_conv_or_pool); end
        total++; if (event_count !== 16'd0) begin bad++; $display("FAIL rst_ev_cnt: got %0d want 0", event_count); end
        total++; if (timestep_count !== 16'd0) begin bad++; $display("FAIL rst_ts_cnt: got %0d want 0", timestep_count); end
        rst_n = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rel_in_ready_early: got %b want 0", in_ready); end
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rel_in_ready: got %b want 1", in_ready); end
        total++; if (arb_enable !== 1'b1) begin bad++; $display("FAIL rel_arb_en: got %b want 1", arb_enable); end
    endtask

    task automatic test_single();
        bit ok, ok2;
        int viol;
        logic [EVW-1:0] ev_a, ev_b;
        do_reset();
        ev_a = mk(1'b0, 8'd5, 8'd3, 2'b11);
        ev_b = mk(1'b0, 8'd9, 8'd1, 2'b01);
        push(ev_a, ok); push(ev_b, ok2);
        total++; if (!(ok && ok2)) begin bad++; $display("FAIL single_push: got %b%b want 11", ok, ok2); end
        wait_valid(ok);
        total++; if (!ok) begin bad++; $display("FAIL single_valid_timeout: got 0 want 1"); end
        exp_ev = sb.pop_front();
        total++; if (conv_event !== exp_ev) begin bad++; $display("FAIL single_event: got %h want %h", conv_event, exp_ev); end
        viol = 0;
        repeat (3) begin
            @(negedge clk);
            if (conv_event_valid !== 1'b1 || conv_event !== exp_ev) viol++;
        end
        total++; if (viol != 0) begin bad++; $display("FAIL single_hold: got %0d drops want 0", viol); end
        @(posedge clk); #1; conv_event_ack = 1'b1; conv_busy = 1'b1; arb_active = 1'b1;
        @(posedge clk); #1; conv_event_ack = 1'b0;
        viol = 0;
        repeat (10) begin
            @(negedge clk);
            if (conv_event_valid !== 1'b0) viol++;
        end
        total++; if (viol != 0) begin bad++; $display("FAIL single_busy_dispatch: got %0d valid cycles want 0", viol); end
        total++; if (event_count !== 16'(ST)) begin bad++; $display("FAIL single_ev_cnt1: got %0d want %0d", event_count, ST); end
        @(posedge clk); #1; conv_busy = 1'b0;
        viol = 0;
        repeat (3) begin
            @(negedge clk);
            if (conv_event_valid !== 1'b0) viol++;
        end
        total++; if (viol != 0) begin bad++; $display("FAIL single_arb_dispatch: got %0d valid cycles want 0", viol); end
        @(posedge clk); #1; arb_active = 1'b0;
        wait_valid(ok);
        exp_ev = sb.pop_front();
        total++; if (!ok || conv_event !== exp_ev) begin bad++; $display("FAIL single_second: got %h want %h", conv_event, exp_ev); end
        pulse_ack();
        @(negedge clk);
        total++; if (event_count !== 16'(2 * ST)) begin bad++; $display("FAIL single_ev_cnt2: got %0d want %0d", event_count, 2 * ST); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int viol, nok;
        logic [EVW-1:0] evs [4];
        do_reset();
        evs[0] = mk(1'b0, 8'd0, 8'd0, 2'b01);
        evs[1] = mk(1'b0, 8'd0, 8'd5, 2'b10);
        evs[2] = mk(1'b0, 8'd7, 8'd2, 2'b11);
        evs[3] = mk(1'b0, 8'd255, 8'd128, 2'b01);
        nok = 0;
        for (int i = 0; i < 4; i++) begin
            push(evs[i], ok);
            if (!ok) nok++;
        end
        total++; if (nok != 0) begin bad++; $display("FAIL b2b_push: got %0d stalls want 0", nok); end
        viol = 0;
        for (int i = 0; i < 4; i++) begin
            wait_valid(ok);
            exp_ev = sb.pop_front();
            total++; if (!ok || conv_event !== exp_ev) begin bad++; $display("FAIL b2b_order%0d: got %h want %h", i, conv_event, exp_ev); end
            pulse_ack();
            @(negedge clk);
            if (conv_event_valid !== 1'b0) viol++;
        end
        total++; if (viol != 0) begin bad++; $display("FAIL b2b_gap: got %0d overlaps want 0", viol); end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL b2b_left: got %0d want 0", sb.size()); end
        total++; if (event_count !== 16'(4 * ST)) begin bad++; $display("FAIL b2b_ev_cnt: got %0d want %0d", event_count, 4 * ST); end
    endtask

    task automatic test_pool();
        bit ok, ok2;
        int n, ps, vmode, vval;
        logic [EVW-1:0] ev_s;
        do_reset();
        ev_s = mk(1'b0, 8'd12, 8'd34, 2'b10);
        push(mk(1'b1, 8'd0, 8'd0, 2'b00), ok); push(ev_s, ok2);
        n = 0; ok = 1'b0;
        while (n < 100 && !ok) begin
            @(negedge clk);
            ok = pool_start;
            n++;
        end
        total++; if (!ok) begin bad++; $display("FAIL pool_start_timeout: got 0 want 1"); end
        total++; if (arb_conv_or_pool !== 1'b0 || conv_event_valid !== 1'b0) begin
            bad++; $display("FAIL pool_start_mode: got mode=%b valid=%b want 0 0", arb_conv_or_pool, conv_event_valid);
        end
        ps = 1; vmode = 0; vval = 0;
        repeat (20) begin
            @(negedge clk);
            if (pool_start) ps++;
            if (arb_conv_or_pool !== 1'b0) vmode++;
            if (conv_event_valid !== 1'b0) vval++;
        end
        total++; if (ps != 1) begin bad++; $display("FAIL pool_pulses: got %0d want 1", ps); end
        total++; if (vmode != 0) begin bad++; $display("FAIL pool_wait_mode: got %0d bad cycles want 0", vmode); end
        total++; if (vval != 0) begin bad++; $display("FAIL pool_wait_dispatch: got %0d valid cycles want 0", vval); end
        pulse_done();
        @(negedge clk);
        total++; if (arb_conv_or_pool !== 1'b1) begin bad++; $display("FAIL pool_return: got %b want 1", arb_conv_or_pool); end
        wait_valid(ok);
        exp_ev = sb.pop_front();
        total++; if (!ok || conv_event !== exp_ev || arb_conv_or_pool !== 1'b1) begin
            bad++; $display("FAIL pool_then_spike: got %h mode %b want %h mode 1", conv_event, arb_conv_or_pool, exp_ev);
        end
        pulse_ack();
        @(negedge clk);
        total++; if (timestep_count !== 16'(ST)) begin bad++; $display("FAIL pool_ts_cnt: got %0d want %0d", timestep_count, ST); end
    endtask

    task automatic test_full();
        bit ok;
        int nok, viol;
        logic [EVW-1:0] ev9;
        do_reset();
        nok = 0;
        for (int i = 0; i < 8; i++) begin
            push(mk(1'b0, 8'(i + 1), 8'(2 * i), 2'(i)), ok);
            if (!ok) nok++;
        end
        total++; if (nok != 0) begin bad++; $display("FAIL full_fill: got %0d stalls want 0", nok); end
        @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b want 0", in_ready); end
        exp_ev = sb.pop_front();
        total++; if (conv_event_valid !== 1'b1 || conv_event !== exp_ev) begin
            bad++; $display("FAIL full_head: got %h want %h", conv_event, exp_ev);
        end
        ev9 = mk(1'b0, 8'hAA, 8'h55, 2'b11);
        @(posedge clk); #1;
        in_event = ev9; in_valid = 1'b1; sb.push_back(ev9);
        viol = 0;
        repeat (3) begin
            @(negedge clk);
            if (in_ready !== 1'b0) viol++;
        end
        total++; if (viol != 0) begin bad++; $display("FAIL full_ninth_early: got %0d ready cycles want 0", viol); end
        @(posedge clk); #1; conv_event_ack = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_pop_cycle: got %b want 0", in_ready); end
        @(posedge clk); #1; conv_event_ack = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_after_ack: got %b want 1", in_ready); end
        @(posedge clk); #1; in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wait_valid(ok);
            exp_ev = sb.pop_front();
            total++; if (!ok || conv_event !== exp_ev) begin bad++; $display("FAIL full_drain%0d: got %h want %h", i, conv_event, exp_ev); end
            pulse_ack();
        end
        @(negedge clk);
        total++; if (sb.size() != 0 || event_count !== 16'(9 * ST)) begin
            bad++; $display("FAIL full_end: got left=%0d cnt=%0d want 0 %0d", sb.size(), event_count, 9 * ST);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n, viol;
        do_reset();
        push(mk(1'b1, 8'd0, 8'd0, 2'b00), ok);
        n = 0; ok = 1'b0;
        while (n < 100 && !ok) begin
            @(negedge clk);
            ok = pool_start;
            n++;
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (!ok || in_ready !== 1'b0 || arb_enable !== 1'b0 || arb_conv_or_pool !== 1'b1 || pool_start !== 1'b0) begin
            bad++; $display("FAIL mid_pool_rst: got rdy=%b en=%b mode=%b ps=%b want 0 0 1 0",
                            in_ready, arb_enable, arb_conv_or_pool, pool_start);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        pulse_done();
        viol = 0;
        repeat (5) begin
            @(negedge clk);
            if (arb_conv_or_pool !== 1'b1 || pool_start !== 1'b0 || in_ready !== 1'b1) viol++;
        end
        total++; if (viol != 0 || timestep_count !== 16'd0) begin
            bad++; $display("FAIL mid_pool_stray: got %0d bad cycles cnt=%0d want 0 0", viol, timestep_count);
        end
        push(mk(1'b0, 8'd3, 8'd4, 2'b01), ok);
        wait_valid(ok);
        exp_ev = sb.pop_front();
        total++; if (!ok || conv_event !== exp_ev) begin bad++; $display("FAIL mid_disp_event: got %h want %h", conv_event, exp_ev); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (conv_event_valid !== 1'b0 || conv_event !== '0 || in_ready !== 1'b0 || event_count !== 16'd0) begin
            bad++; $display("FAIL mid_disp_rst: got v=%b ev=%h rdy=%b cnt=%0d want 0 0 0 0",
                            conv_event_valid, conv_event, in_ready, event_count);
        end
        sb.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        pulse_ack();
        viol = 0;
        repeat (6) begin
            @(negedge clk);
            if (conv_event_valid !== 1'b0) viol++;
        end
        total++; if (viol != 0 || event_count !== 16'd0) begin
            bad++; $display("FAIL mid_disp_stray: got %0d valid cycles cnt=%0d want 0 0", viol, event_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_pool();
        test_full();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
